// File: rtl/sid_pkg.sv
// Shared types and constants for the SID DAC output stage.
//   sample_t           : one 12-bit DAC word
//   state_t            : serializer FSM states
//   to_offset_binary() : two's complement -> offset binary by flipping the MSB
package sid_pkg;

  localparam int DAC_BITS  = 12;
  localparam int BIT_IDX_W = $clog2(DAC_BITS);

  typedef logic [DAC_BITS-1:0]  sample_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Adding half scale modulo 2^12 is the same as flipping bit 11, which is
  // all the DAC7611 needs to see a signed sample as unipolar.
  function automatic sample_t to_offset_binary(input sample_t s, input bit is_signed);
    sample_t r;
    r = s;
    if (is_signed) r[DAC_BITS-1] = ~s[DAC_BITS-1];
    return r;
  endfunction

endpackage

// File: rtl/sid_clk_div.sv
// Half-period timer for the DAC serial clock.
// Down-counter that pulses tick for one cycle each time it reaches zero,
// i.e. once every CLK_DIV cycles after a clear.
// Ports:
//   wb_clk_i  in  system clock
//   wb_rst_i  in  synchronous active-high reset (counter forced to 0)
//   clr       in  restart the half-period (asserted on sample accept)
//   tick      out one-cycle strobe marking the end of a half-period
module sid_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count; with CLK_DIV = 1 the counter sits at zero and ticks
  // every cycle.
  assign tick = (cnt == '0);

endmodule

// File: rtl/sid_dac_serializer.sv
// Stereo output stage driving two DAC7611 12-bit serial DACs.
// One sample pair is taken per valid/ready handshake and both words are
// shifted MSB first on dac_dat_1/dac_dat_2 against a shared dac_clk, then
// committed with a shared active-low dac_le pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pins idle (clk=1, le=1), sample_ready=1, waiting for valid
// SHIFT | 12 bits, each 2*CLK_DIV cycles: clk low half then high half
// LATCH | dac_le held low for LE_WIDTH cycles, then back to IDLE
//
// Ports:
//   wb_clk_i      in   system clock, rising edge
//   wb_rst_i      in   synchronous active-high reset
//   sample_l      in   12-bit channel-1 sample -> dac_dat_1
//   sample_r      in   12-bit channel-2 sample -> dac_dat_2
//   sample_valid  in   sample pair present
//   sample_ready  out  pair can be accepted (IDLE only)
//   busy          out  frame in progress (SHIFT or LATCH)
//   dac_clk       out  DAC serial clock, idles high, DAC samples on rise
//   dac_dat_1     out  serial data, DAC 1
//   dac_dat_2     out  serial data, DAC 2
//   dac_le        out  active-low load strobe, both DACs
module sid_dac_serializer
  import sid_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int LE_WIDTH  = 2,
  parameter int SIGNED_IN = 1
) (
  input  logic    wb_clk_i,
  input  logic    wb_rst_i,
  input  sample_t sample_l,
  input  sample_t sample_r,
  input  logic    sample_valid,
  output logic    sample_ready,
  output logic    busy,
  output logic    dac_clk,
  output logic    dac_dat_1,
  output logic    dac_dat_2,
  output logic    dac_le
);

  localparam int LEW = (LE_WIDTH > 1) ? $clog2(LE_WIDTH) : 1;
  localparam logic [LEW-1:0] LE_RELOAD = LEW'(LE_WIDTH - 1);
  localparam bit_idx_t MSB_IDX = BIT_IDX_W'(DAC_BITS - 1);

  state_t         state;
  sample_t        shreg_1;
  sample_t        shreg_2;
  bit_idx_t       bit_cnt;
  logic [LEW-1:0] le_cnt;

  logic    accept;
  logic    div_tick;
  sample_t conv_l;
  sample_t conv_r;

  // sample_ready is a registered copy of (state == IDLE), so this is only
  // true in IDLE; reset has priority in the state register below, which is
  // what makes a handshake during reset a no-op.
  assign accept = sample_valid && sample_ready;

  assign conv_l = to_offset_binary(sample_l, SIGNED_IN != 0);
  assign conv_r = to_offset_binary(sample_r, SIGNED_IN != 0);

  // Restarting the divider on accept aligns the first low half-period with
  // the cycle right after the handshake.
  sid_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (accept),
    .tick     (div_tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      sample_ready <= 1'b1;
      busy         <= 1'b0;
      dac_clk      <= 1'b1;
      dac_le       <= 1'b1;
      dac_dat_1    <= 1'b0;
      dac_dat_2    <= 1'b0;
      shreg_1      <= '0;
      shreg_2      <= '0;
      bit_cnt      <= MSB_IDX;
      le_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg_1      <= conv_l;
            shreg_2      <= conv_r;
            // MSB goes on the pins together with the first clock fall.
            dac_dat_1    <= conv_l[DAC_BITS-1];
            dac_dat_2    <= conv_r[DAC_BITS-1];
            dac_clk      <= 1'b0;
            bit_cnt      <= MSB_IDX;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
            state        <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_tick) begin
            if (!dac_clk) begin
              // Mid-bit: rising edge, data untouched on both sides of it.
              dac_clk <= 1'b1;
            end else if (bit_cnt == '0) begin
              // Last bit done: clock parks high, data holds bit 0.
              dac_le <= 1'b0;
              le_cnt <= LE_RELOAD;
              state  <= LATCH;
            end else begin
              // Bit boundary: data changes together with the clock fall.
              shreg_1   <= shreg_1 << 1;
              shreg_2   <= shreg_2 << 1;
              dac_dat_1 <= shreg_1[DAC_BITS-2];
              dac_dat_2 <= shreg_2[DAC_BITS-2];
              dac_clk   <= 1'b0;
              bit_cnt   <= bit_cnt - 1'b1;
            end
          end
        end

        LATCH: begin
          if (le_cnt == '0) begin
            dac_le       <= 1'b1;
            busy         <= 1'b0;
            sample_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            le_cnt <= le_cnt - 1'b1;
          end
        end

        default: begin
          dac_clk      <= 1'b1;
          dac_le       <= 1'b1;
          busy         <= 1'b0;
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
